// File: rtl/dram_request_arbiter.sv
// Two-port arbiter in front of a single-outstanding-read DRAM controller port.
// Holds the granted request stable for the whole transaction and monitors the controller handshake.
module dram_request_arbiter #(
    parameter int unsigned FIXED_PRIORITY = 0,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic         main_clk,
    input  logic         main_rst_n,
    input  logic         req0_valid,
    input  logic [21:0]  req0_addr_read,
    input  logic [10:0]  req0_addr_write_upper,
    input  logic [127:0] req0_lane_wb,
    input  logic         req0_dirty,
    output logic         req0_ack,
    input  logic         req1_valid,
    input  logic [21:0]  req1_addr_read,
    input  logic [10:0]  req1_addr_write_upper,
    input  logic [127:0] req1_lane_wb,
    input  logic         req1_dirty,
    output logic         req1_ack,
    output logic [127:0] rd_lane,
    output logic [10:0]  addr_req_read_dram_side_dram,
    output logic [10:0]  addr_req_write_dram_side_dram,
    output logic [10:0]  addr_req_common_side_dram,
    output logic [127:0] lane_from_cache_to_dram_side_dram,
    output logic         dram_controller_entry_dirty_side_dram,
    output logic         dram_controller_req_read_pulse_side_dram,
    input  logic         dram_controller_ack_read_pulse_side_dram,
    input  logic [127:0] lane_from_dram_to_cache_side_dram,
    output logic         busy,
    output logic         grant_id,
    output logic         timeout_err,
    output logic         proto_err
);
    localparam int unsigned      CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TO_MAX = CNT_W'(TIMEOUT_CYCLES);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]       state;
    logic             last_grant;
    logic             armed;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_next;
    logic             any_valid;
    logic             win;
    logic [21:0]      win_addr_read;
    logic [10:0]      win_addr_write_upper;
    logic [127:0]     win_lane_wb;
    logic             win_dirty;

    always_comb begin
        any_valid = req0_valid | req1_valid;
        win       = req1_valid & ~req0_valid;
        if (req0_valid && req1_valid) begin
            win = (FIXED_PRIORITY != 0) ? 1'b0 : ~last_grant;
        end
        win_addr_read        = win ? req1_addr_read        : req0_addr_read;
        win_addr_write_upper = win ? req1_addr_write_upper : req0_addr_write_upper;
        win_lane_wb          = win ? req1_lane_wb          : req0_lane_wb;
        win_dirty            = win ? req1_dirty            : req0_dirty;
        wait_cnt_next        = (wait_cnt == TO_MAX) ? wait_cnt : wait_cnt + 1'b1;
    end

    always_ff @(posedge main_clk) begin
        if (!main_rst_n) begin
            state                                    <= S_IDLE;
            last_grant                               <= 1'b1;
            armed                                    <= 1'b0;
            wait_cnt                                 <= '0;
            req0_ack                                 <= 1'b0;
            req1_ack                                 <= 1'b0;
            rd_lane                                  <= '0;
            addr_req_read_dram_side_dram             <= '0;
            addr_req_write_dram_side_dram            <= '0;
            addr_req_common_side_dram                <= '0;
            lane_from_cache_to_dram_side_dram        <= '0;
            dram_controller_entry_dirty_side_dram    <= 1'b0;
            dram_controller_req_read_pulse_side_dram <= 1'b0;
            busy                                     <= 1'b0;
            grant_id                                 <= 1'b0;
            timeout_err                              <= 1'b0;
            proto_err                                <= 1'b0;
        end else begin
            dram_controller_req_read_pulse_side_dram <= 1'b0;
            req0_ack                                 <= 1'b0;
            req1_ack                                 <= 1'b0;
            if (dram_controller_ack_read_pulse_side_dram && state != S_WAIT) begin
                proto_err <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (any_valid) begin
                        // Side outputs are only written here, so they hold until the next grant.
                        addr_req_read_dram_side_dram             <= win_addr_read[21:11];
                        addr_req_write_dram_side_dram            <= win_addr_write_upper;
                        addr_req_common_side_dram                <= win_addr_read[10:0];
                        lane_from_cache_to_dram_side_dram        <= win_lane_wb;
                        dram_controller_entry_dirty_side_dram    <= win_dirty;
                        dram_controller_req_read_pulse_side_dram <= 1'b1;
                        grant_id                                 <= win;
                        wait_cnt                                 <= '0;
                        busy                                     <= 1'b1;
                        state                                    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (dram_controller_ack_read_pulse_side_dram) begin
                        rd_lane <= lane_from_dram_to_cache_side_dram;
                        armed   <= 1'b1;
                        state   <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt_next;
                        // Timeout is suppressed until the controller has answered once (init period).
                        if (armed && wait_cnt_next == TO_MAX) begin
                            timeout_err <= 1'b1;
                        end
                    end
                end
                S_RESP: begin
                    if (grant_id) begin
                        req1_ack <= 1'b1;
                    end else begin
                        req0_ack <= 1'b1;
                    end
                    last_grant <= grant_id;
                    busy       <= 1'b0;
                    state      <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dram_request_arbiter.sv
// Randomized and directed bench for dram_request_arbiter against a transaction-level reference model.
// A round-robin and a fixed-priority instance share all inputs.
module tb_dram_request_arbiter;
    localparam int unsigned T = 1023;

    logic main_clk = 1'b0;
    always #5 main_clk = ~main_clk;

    logic         main_rst_n;
    logic         v  [2];
    logic [21:0]  ar [2];
    logic [10:0]  aw [2];
    logic [127:0] wb [2];
    logic         dt [2];
    logic         ctl_ack;
    logic [127:0] ctl_lane;

    logic r_ack0, r_ack1, r_dirty, r_pulse, r_busy, r_gid, r_te, r_pe;
    logic [127:0] r_rd, r_lane;
    logic [10:0]  r_ard, r_awr, r_acm;
    logic f_ack0, f_ack1, f_dirty, f_pulse, f_busy, f_gid, f_te, f_pe;
    logic [127:0] f_rd, f_lane;
    logic [10:0]  f_ard, f_awr, f_acm;

    dram_request_arbiter #(.FIXED_PRIORITY(0), .TIMEOUT_CYCLES(T)) dut (
        .main_clk(main_clk), .main_rst_n(main_rst_n),
        .req0_valid(v[0]), .req0_addr_read(ar[0]), .req0_addr_write_upper(aw[0]),
        .req0_lane_wb(wb[0]), .req0_dirty(dt[0]), .req0_ack(r_ack0),
        .req1_valid(v[1]), .req1_addr_read(ar[1]), .req1_addr_write_upper(aw[1]),
        .req1_lane_wb(wb[1]), .req1_dirty(dt[1]), .req1_ack(r_ack1),
        .rd_lane(r_rd), .addr_req_read_dram_side_dram(r_ard),
        .addr_req_write_dram_side_dram(r_awr), .addr_req_common_side_dram(r_acm),
        .lane_from_cache_to_dram_side_dram(r_lane),
        .dram_controller_entry_dirty_side_dram(r_dirty),
        .dram_controller_req_read_pulse_side_dram(r_pulse),
        .dram_controller_ack_read_pulse_side_dram(ctl_ack),
        .lane_from_dram_to_cache_side_dram(ctl_lane),
        .busy(r_busy), .grant_id(r_gid), .timeout_err(r_te), .proto_err(r_pe)
    );

    dram_request_arbiter #(.FIXED_PRIORITY(1), .TIMEOUT_CYCLES(T)) dut_fp (
        .main_clk(main_clk), .main_rst_n(main_rst_n),
        .req0_valid(v[0]), .req0_addr_read(ar[0]), .req0_addr_write_upper(aw[0]),
        .req0_lane_wb(wb[0]), .req0_dirty(dt[0]), .req0_ack(f_ack0),
        .req1_valid(v[1]), .req1_addr_read(ar[1]), .req1_addr_write_upper(aw[1]),
        .req1_lane_wb(wb[1]), .req1_dirty(dt[1]), .req1_ack(f_ack1),
        .rd_lane(f_rd), .addr_req_read_dram_side_dram(f_ard),
        .addr_req_write_dram_side_dram(f_awr), .addr_req_common_side_dram(f_acm),
        .lane_from_cache_to_dram_side_dram(f_lane),
        .dram_controller_entry_dirty_side_dram(f_dirty),
        .dram_controller_req_read_pulse_side_dram(f_pulse),
        .dram_controller_ack_read_pulse_side_dram(ctl_ack),
        .lane_from_dram_to_cache_side_dram(ctl_lane),
        .busy(f_busy), .grant_id(f_gid), .timeout_err(f_te), .proto_err(f_pe)
    );

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    // Reference model state (transaction level)
    bit           m_last, m_armed, m_te, m_pe;
    logic [127:0] m_rd;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge main_clk);
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset();
        m_last  = 1'b1;
        m_armed = 1'b0;
        m_te    = 1'b0;
        m_pe    = 1'b0;
        m_rd    = '0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rr_rd"},   r_rd,   '0);
        chk({tag, "_rr_lane"}, r_lane, '0);
        chk({tag, "_rr_misc"}, 128'({r_ack0, r_ack1, r_ard, r_awr, r_acm, r_dirty, r_pulse,
                                      r_busy, r_gid, r_te, r_pe}), '0);
        chk({tag, "_fp_rd"},   f_rd,   '0);
        chk({tag, "_fp_lane"}, f_lane, '0);
        chk({tag, "_fp_misc"}, 128'({f_ack0, f_ack1, f_ard, f_awr, f_acm, f_dirty, f_pulse,
                                      f_busy, f_gid, f_te, f_pe}), '0);
    endtask

    task automatic randomize_port(input int p);
        ar[p] = 22'($urandom);
        aw[p] = 11'($urandom);
        wb[p] = rnd128();
        dt[p] = 1'($urandom);
    endtask

    // One complete transaction from an IDLE cycle with at least one valid request.
    task automatic run_txn(input int unsigned dly, input logic [127:0] rlane,
                           input bit drop, input bit scramble);
        bit           w, wf, exp_te;
        logic [21:0]  e_ar;
        logic [10:0]  e_aw;
        logic [127:0] e_wb;
        logic         e_dt;
        if (v[0] && v[1]) w = ~m_last;
        else              w = v[1];
        wf   = v[0] ? 1'b0 : 1'b1;
        e_ar = ar[w];
        e_aw = aw[w];
        e_wb = wb[w];
        e_dt = dt[w];
        step();
        chk("pulse_hi", 128'(r_pulse), 128'(1));
        chk("grant", 128'(r_gid), 128'(w));
        chk("fp_pulse_hi", 128'(f_pulse), 128'(1));
        chk("fp_grant", 128'(f_gid), 128'(wf));
        for (int unsigned k = 0; k <= dly; k++) begin
            if (k != 0) begin
                step();
                chk("pulse_lo", 128'(r_pulse), 128'(0));
            end
            exp_te = m_te || (m_armed && k >= T);
            chk("busy_wait", 128'(r_busy), 128'(1));
            chk("hold_read", 128'(r_ard), 128'(e_ar[21:11]));
            chk("hold_common", 128'(r_acm), 128'(e_ar[10:0]));
            chk("hold_write", 128'(r_awr), 128'(e_aw));
            chk("hold_lane", r_lane, e_wb);
            chk("hold_dirty", 128'(r_dirty), 128'(e_dt));
            chk("wait_acks", 128'({r_ack0, r_ack1}), 128'(0));
            chk("wait_rd", r_rd, m_rd);
            chk("wait_timeout", 128'(r_te), 128'(exp_te));
            chk("wait_proto", 128'(r_pe), 128'(m_pe));
            if (scramble) begin
                for (int p = 0; p < 2; p++) begin
                    randomize_port(p);
                    v[p] = 1'($urandom);
                end
            end
            ctl_lane = rnd128();
            if (k == dly) begin
                ctl_ack  = 1'b1;
                ctl_lane = rlane;
            end
        end
        step();
        ctl_ack  = 1'b0;
        ctl_lane = rnd128();
        m_te     = m_te || (m_armed && dly >= T);
        m_armed  = 1'b1;
        m_rd     = rlane;
        chk("resp_busy", 128'(r_busy), 128'(1));
        chk("resp_rd", r_rd, m_rd);
        chk("resp_acks", 128'({r_ack0, r_ack1}), 128'(0));
        chk("resp_timeout", 128'(r_te), 128'(m_te));
        step();
        m_last = w;
        chk("ack_win", 128'(w ? r_ack1 : r_ack0), 128'(1));
        chk("ack_other", 128'(w ? r_ack0 : r_ack1), 128'(0));
        chk("ack_rd", r_rd, m_rd);
        chk("ack_busy", 128'(r_busy), 128'(0));
        chk("ack_hold_read", 128'(r_ard), 128'(e_ar[21:11]));
        chk("fp_ack_win", 128'(wf ? f_ack1 : f_ack0), 128'(1));
        if (drop) v[w] = 1'b0;
    endtask

    initial begin
        main_rst_n = 1'b0;
        ctl_ack    = 1'b0;
        ctl_lane   = '0;
        for (int p = 0; p < 2; p++) begin
            v[p] = 1'b0;
            randomize_port(p);
        end
        model_reset();
        repeat (3) step();
        chk_zero("reset");
        main_rst_n = 1'b1;

        // Controller still initialising: long wait must not flag a timeout.
        v[0] = 1'b1;
        run_txn(2000, rnd128(), 1'b1, 1'b0);
        chk("no_timeout_unarmed", 128'(r_te), 128'(0));

        ar[0] = 22'h2A5F3C;
        dt[0] = 1'b0;
        v[0]  = 1'b1;
        run_txn(20, rnd128(), 1'b1, 1'b1);
        chk("tp_read_11", 128'(r_ard), 128'(11'h54B));
        chk("tp_common_11", 128'(r_acm), 128'(11'h73C));

        aw[1] = 11'h1FF;
        dt[1] = 1'b1;
        wb[1] = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
        v[1]  = 1'b1;
        run_txn(15, rnd128(), 1'b1, 1'b1);
        chk("tp_write_1ff", 128'(r_awr), 128'(11'h1FF));
        chk("tp_wb_lane", r_lane, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D);
        chk("tp_dirty", 128'(r_dirty), 128'(1));

        v[0] = 1'b1;
        run_txn(1100, rnd128(), 1'b1, 1'b0);
        chk("timeout_set", 128'(r_te), 128'(1));
        v[1] = 1'b1;
        run_txn(3, rnd128(), 1'b1, 1'b0);
        chk("timeout_sticky", 128'(r_te), 128'(1));

        ctl_ack  = 1'b1;
        ctl_lane = rnd128();
        step();
        ctl_ack = 1'b0;
        m_pe    = 1'b1;
        chk("spurious_proto", 128'(r_pe), 128'(1));
        chk("spurious_rd", r_rd, m_rd);
        chk("spurious_busy", 128'(r_busy), 128'(0));

        v[0] = 1'b1;
        step();
        chk("pre_rst_pulse", 128'(r_pulse), 128'(1));
        v[0] = 1'b0;
        repeat (2) step();
        main_rst_n = 1'b0;
        step();
        chk_zero("mid_reset");
        main_rst_n = 1'b1;
        model_reset();

        // Back-to-back ties: round-robin alternates, fixed priority stays on port 0.
        for (int p = 0; p < 2; p++) begin
            randomize_port(p);
            v[p] = 1'b1;
        end
        for (int i = 0; i < 4; i++) begin
            run_txn(2 + 3 * i, rnd128(), 1'b0, 1'b0);
            chk("tie_seq_rr", 128'(r_gid), 128'(i % 2));
            chk("tie_seq_fp", 128'(f_gid), 128'(0));
        end
        v[0] = 1'b0;
        v[1] = 1'b0;
        step();

        for (int n = 0; n < 80; n++) begin
            int unsigned gap, mask;
            if (!v[0] && !v[1]) begin
                gap = $urandom_range(0, 3);
                for (int unsigned g = 0; g < gap; g++) begin
                    step();
                    chk("idle_pulse", 128'(r_pulse), 128'(0));
                    chk("idle_busy", 128'(r_busy), 128'(0));
                    chk("idle_acks", 128'({r_ack0, r_ack1}), 128'(0));
                end
                mask = $urandom_range(1, 3);
                for (int p = 0; p < 2; p++) begin
                    if (mask[p]) begin
                        randomize_port(p);
                        v[p] = 1'b1;
                    end
                end
            end else if ($urandom_range(0, 1) == 1) begin
                for (int p = 0; p < 2; p++) begin
                    if (!v[p]) begin
                        randomize_port(p);
                        v[p] = 1'b1;
                    end
                end
            end
            run_txn($urandom_range(1, 8), rnd128(), 1'b1, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/dram_request_arbiter.md
Name: dram_request_arbiter

Overview:
- Shares the single-outstanding-read DRAM controller port between two cache-side requesters (port 0 = instruction cache, port 1 = data cache).
- Accepts a 128-bit line fill with optional dirty write-back from each port, arbitrates between them, and holds the multiplexed address, write-back lane and dirty flag stable for the whole transaction.
- Issues the controller's one-cycle read pulse, captures the returned lane, and acknowledges the winning port.
- Also monitors the controller handshake for hangs and protocol violations.

Parameters:
- FIXED_PRIORITY, 0, 0 = round-robin; 1 = port 0 always wins simultaneous requests.
- TIMEOUT_CYCLES, 1023, WAIT-state cycle count at which timeout_err is raised; fits a 10-bit counter.

Ports:
- main_clk  in  1  sole clock; all logic on the rising edge.
- main_rst_n  in  1  synchronous, active-low reset.
- req0_valid  in  1  level request; held until req0_ack.
- req0_addr_read  in  22  line address to fill.
- req0_addr_write_upper  in  11  upper write-back address; lower 11 bits are shared with req0_addr_read[10:0].
- req0_lane_wb  in  128  write-back data.
- req0_dirty  in  1  write-back required.
- req0_ack  out  1  one-cycle completion pulse.
- req1_valid, req1_addr_read, req1_addr_write_upper, req1_lane_wb, req1_dirty, req1_ack: same as port 0.
- rd_lane  out  128  fill data; valid in the req*_ack cycle and held until the next capture.
- addr_req_read_dram_side_dram  out  11  = granted addr_read[21:11].
- addr_req_write_dram_side_dram  out  11  = granted addr_write_upper.
- addr_req_common_side_dram  out  11  = granted addr_read[10:0].
- lane_from_cache_to_dram_side_dram  out  128  granted write-back lane.
- dram_controller_entry_dirty_side_dram  out  1  granted dirty flag.
- dram_controller_req_read_pulse_side_dram  out  1  one-cycle request pulse.
- dram_controller_ack_read_pulse_side_dram  in  1  one-cycle controller ack.
- lane_from_dram_to_cache_side_dram  in  128  controller read lane.
- busy  out  1  high in WAIT and RESP.
- grant_id  out  1  port currently or last granted.
- timeout_err  out  1  sticky.
- proto_err  out  1  sticky.

Behaviour:
- All outputs are registered. Reset value of every output is 0. Internal resets: last_grant=1, so port 0 wins the first tie; armed=0; timeout counter=0; state=IDLE.

State machine: IDLE -> WAIT -> RESP -> IDLE.
- IDLE, no valid input: stay.
- IDLE, any valid input: choose winner.
  - FIXED_PRIORITY=1: port 0 wins when both are valid.
  - Otherwise: the port != last_grant wins when both are valid.
  - A single valid port always wins.
- At the grant edge:
  - Latch the winner's fields onto all *_side_dram outputs.
  - Set grant_id.
  - Set the request pulse to 1; it clears on the following edge, so it is exactly 1 cycle wide.
  - Clear the timeout counter and enter WAIT.
- Side outputs stay constant from the pulse cycle until RESP exits. The controller samples the write fields several cycles after the pulse, so this hold is mandatory.
- Requester fields changing after grant are ignored.
- Dropping valid before grant withdraws the request. Dropping it after grant is ignored; the ack is still issued.
- WAIT, on controller ack:
  - rd_lane <= lane_from_dram_to_cache_side_dram.
  - armed <= 1.
  - Enter RESP.
- WAIT, no ack: the counter increments, saturating at TIMEOUT_CYCLES. If the counter equals TIMEOUT_CYCLES and armed=1, set timeout_err. The block keeps waiting and never aborts.
- Before the first ack ever (armed=0), no timeout is flagged, because controller initialisation takes about 65k cycles.
- RESP:
  - Pulse req<grant_id>_ack for 1 cycle.
  - last_grant <= grant_id.
  - Return to IDLE.
- Latency: valid seen in IDLE at cycle t -> request pulse at t+1. Controller ack at cycle a -> req ack at a+2.
- Minimum spacing: 3 cycles between a controller ack and the next request pulse. A pulse is never coincident with a controller ack.
- A controller ack in IDLE or RESP sets proto_err and is otherwise ignored; rd_lane is unchanged.
- Only one transaction is outstanding at a time.
- Reset mid-transaction: all state returns to reset values immediately and the request pulse is low. Reset must only be applied together with system reset, since the controller itself has no reset.

Test Plan:
- Single port 0 read: addr_read=22'h2A5F3C, dirty=0, controller acks 20 cycles after the pulse. Required: pulse width 1; read=11'h54B, common=11'h73C held constant; req0_ack 2 cycles after the controller ack with rd_lane equal to the returned lane; req1_ack never pulses.
- Both ports valid continuously, FIXED_PRIORITY=0. Required: grant sequence 0,1,0,1; each port's fields appear only while it is granted.
- Same stimulus with FIXED_PRIORITY=1. Required: port 0 granted on every transaction while it stays valid; port 1 is granted only when port 0 is idle.
- Dirty write-back: port 1 with addr_write_upper=11'h1FF, dirty=1, lane_wb=128'hDEADBEEF_... Required: write=11'h1FF and the lane stay stable for all WAIT cycles, including 10 cycles after the pulse.
- Timeout: before any ack, withhold ack for 2000 cycles -> timeout_err=0. After one completed transaction, withhold ack -> timeout_err=1 at exactly 1023 WAIT cycles and stays set.
- Spurious controller ack in IDLE -> proto_err=1, rd_lane unchanged. Reset asserted in WAIT -> next cycle all outputs 0; first tie after reset goes to port 0.
